csa_accumulator: RTL and testbench
==================================

Name: csa_accumulator

Overview:
- Multi-operand accumulator that sits upstream of the team's final 8-bit carry-propagate adder stage.
- Reduces a stream of 8-bit operands in carry-save form, one operand per cycle, with no carry propagation during accumulation.
- On the frame's last operand, it resolves the redundant sum/carry pair in DATA_W-bit chunks using the adder_8bit sub-module.
- Presents one binary total per frame on a valid/ready output.

Parameters:
- DATA_W, 8, operand width and resolve chunk width.
- ACC_W, 12, accumulator/result width; must satisfy ACC_W >= DATA_W + clog2(MAX_OPS).
- MAX_OPS, 16, maximum operands per frame.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  operand valid.
- in_ready  out  1  block can accept an operand.
- in_data  in  DATA_W  operand, unsigned.
- in_last  in  1  marks final operand of frame.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts result.
- out_sum  out  ACC_W  frame total, unsigned.
- out_count  out  clog2(MAX_OPS+1)  operands in frame.
- out_trunc  out  1  frame was force-terminated at MAX_OPS.

Behaviour:
- Reset: asynchronous, active-high. All outputs reset to 0: in_ready=0 during reset, out_valid=0, out_sum=0, out_count=0, out_trunc=0. Internal S, C, count and chunk index are cleared; state=ACCUM. in_ready rises on the first clk edge after rst deasserts.
- States:
  - ACCUM: in_ready=1.
  - RESOLVE: in_ready=0.
  - OUTPUT: in_ready=0, out_valid=1.
- ACCUM, beat accepted (in_valid & in_ready at rising edge): S <= S ^ C ^ X and C <= (maj(S,C,X)) << 1, where X = zero-extended in_data, all ACC_W bits. count <= count+1.
- ACCUM transition: if in_last=1, or count == MAX_OPS-1 (this beat is the MAX_OPS-th), go to RESOLVE.
  - out_trunc is set only when the forced end occurs with in_last=0.
  - After a forced end, subsequent beats start a new frame; in_last is not required.
- RESOLVE: R = ceil(ACC_W/DATA_W) cycles (2 at defaults).
  - Chunk i adds S[i] + C[i] + registered carry using adder_8bit and writes out_sum chunk i.
  - Carry out of the top chunk is discarded; it cannot be nonzero when the ACC_W rule holds.
  - After R cycles, go to OUTPUT.
- Latency: out_valid rises on the edge R+1 cycles after the edge that accepted the last beat (3 at defaults).
- OUTPUT: out_sum, out_count and out_trunc are held stable while out_valid=1 and out_ready=0.
  - On out_valid & out_ready: clear S, C, count and out_trunc; out_valid <= 0; go to ACCUM.
  - in_ready rises the same edge. No overlap of frames.
- in_valid is ignored outside ACCUM. in_data and in_last are don't-care when in_valid=0.
- Single-beat frame (first beat has in_last=1): out_sum = operand, out_count = 1.
- Zero operands: a valid beat with in_data=0 counts normally.
- Reset mid-frame or mid-RESOLVE/OUTPUT: the partial frame is discarded and no output is produced.

Optional Feature:
- Macro CSA_ACC_MAX_EN.
- When defined: adds output port out_max (DATA_W), the largest operand of the frame.
  - Tracked by compare on each accepted beat.
  - Reset to 0 and cleared on the output handshake.
  - Valid with out_valid.
- When undefined: the port and its logic are absent; all other behaviour is identical.

Decomposition:
- Shared package csa_pkg holds:
  - state enum {ACCUM, RESOLVE, OUTPUT};
  - DATA_W and ACC_W defaults;
  - function clog2;
  - constant NUM_CHUNKS = ceil(ACC_W/DATA_W).
- One sub-module, adder_8bit (existing carry-propagate adder: A, B, Sum, CarryOut), is instantiated once and reused across resolve cycles.
- The chunk carry-in is handled by a small wrapper or an added cin input.

Test Plan:
- Reset then frame {3,5,7 last}, out_ready=1 -> out_sum=15, out_count=3, out_trunc=0; out_valid 3 cycles after last beat.
- Single beat 200 with in_last=1 -> out_sum=200, out_count=1.
- 16 beats of 255, none last -> forced end: out_sum=4080, out_count=16, out_trunc=1; next beat 1 with last gives out_sum=1, out_trunc=0.
- Frame {100,100 last} with out_ready=0 for 5 cycles -> out_valid held, out_sum=200 stable, in_ready=0, extra in_valid beats ignored; release -> in_ready=1 next edge.
- Assert rst after 2 beats of frame {10,20,30 last} -> no output. Fresh frame {1,2 last} gives out_sum=3, out_count=2.
- With CSA_ACC_MAX_EN: frame {9,250,17 last} -> out_max=250, out_sum=276. Without the macro, the bench compiles with no out_max port.

Source files
------------

// File: rtl/csa_pkg.sv
// Shared definitions for the carry-save accumulator.
// Holds the FSM state type, default widths, a constant-foldable clog2 and the
// number of resolve chunks at the default widths.
package csa_pkg;

    localparam int unsigned DEF_DATA_W  = 8;
    localparam int unsigned DEF_ACC_W   = 12;
    localparam int unsigned DEF_MAX_OPS = 16;

    typedef enum logic [1:0] {
        ACCUM   = 2'd0,
        RESOLVE = 2'd1,
        OUTPUT  = 2'd2
    } state_e;

    // Ceiling log2; clog2(1) == 0.
    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        for (int unsigned p = 1; p < v; p = p << 1) begin
            r = r + 1;
        end
        return r;
    endfunction

    localparam int unsigned NUM_CHUNKS = (DEF_ACC_W + DEF_DATA_W - 1) / DEF_DATA_W;

endpackage

// File: rtl/adder_8bit.sv
// Existing 8-bit carry-propagate adder, extended with a carry-in so it can be
// chained across resolve chunks.
// Ports: A, B (addends), Cin (carry in), Sum (result), CarryOut (carry out).
module adder_8bit (
    input  logic [7:0] A,
    input  logic [7:0] B,
    input  logic       Cin,
    output logic [7:0] Sum,
    output logic       CarryOut
);

    assign {CarryOut, Sum} = 9'(A) + 9'(B) + 9'(Cin);

endmodule

// File: rtl/csa_accumulator.sv
// Multi-operand carry-save accumulator. Operands are reduced into a redundant
// sum/carry pair with no carry propagation; on the last operand of a frame the
// pair is resolved chunk by chunk through a single reused adder_8bit, and the
// binary total is presented on a valid/ready output.
// Ports:
//   clk, rst                      clock, async active-high reset
//   in_valid/in_ready/in_data/in_last   operand stream
//   out_valid/out_ready           result handshake
//   out_sum, out_count, out_trunc frame total, operand count, forced-end flag
//   out_max                       largest operand (only with CSA_ACC_MAX_EN)
// Build option: define CSA_ACC_MAX_EN to add out_max tracking.
module csa_accumulator
    import csa_pkg::*;
#(
    parameter int unsigned DATA_W  = DEF_DATA_W,
    parameter int unsigned ACC_W   = DEF_ACC_W,
    parameter int unsigned MAX_OPS = DEF_MAX_OPS
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [DATA_W-1:0]              in_data,
    input  logic                           in_last,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [ACC_W-1:0]               out_sum,
    output logic [clog2(MAX_OPS+1)-1:0]    out_count,
`ifdef CSA_ACC_MAX_EN
    output logic [DATA_W-1:0]              out_max,
`endif
    output logic                           out_trunc
);

    localparam int unsigned CNT_W = clog2(MAX_OPS + 1);
    localparam int unsigned NCH   = (ACC_W + DATA_W - 1) / DATA_W;
    localparam int unsigned IDX_W = clog2(NCH + 1);

    state_e              state_q, state_d;
    logic [ACC_W-1:0]    s_q, s_d;
    logic [ACC_W-1:0]    c_q, c_d;
    logic [ACC_W-1:0]    sum_q, sum_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [IDX_W-1:0]    chunk_q, chunk_d;
    logic                cy_q, cy_d;
    logic                trunc_q, trunc_d;
    logic                valid_q, valid_d;
    logic                in_ready_q, in_ready_d;
`ifdef CSA_ACC_MAX_EN
    logic [DATA_W-1:0]   max_q, max_d;
`endif

    logic [ACC_W-1:0]    x_ext;
    int unsigned         shamt;
    logic [DATA_W-1:0]   add_a, add_b, add_sum;
    logic                add_co;

    // Operand selection for the current resolve chunk.
    always_comb begin
        shamt = 32'(chunk_q) * DATA_W;
        add_a = DATA_W'(s_q >> shamt);
        add_b = DATA_W'(c_q >> shamt);
    end

    // Single adder reused for every chunk; carry between chunks lives in cy_q.
    adder_8bit u_adder (
        .A        (add_a),
        .B        (add_b),
        .Cin      (cy_q),
        .Sum      (add_sum),
        .CarryOut (add_co)
    );

    // Next-state and datapath updates.
    always_comb begin
        state_d = state_q;
        s_d     = s_q;
        c_d     = c_q;
        sum_d   = sum_q;
        cnt_d   = cnt_q;
        chunk_d = chunk_q;
        cy_d    = cy_q;
        trunc_d = trunc_q;
        valid_d = valid_q;
`ifdef CSA_ACC_MAX_EN
        max_d   = max_q;
`endif
        x_ext   = ACC_W'(in_data);

        case (state_q)
            ACCUM: begin
                chunk_d = '0;
                cy_d    = 1'b0;
                if (in_valid && in_ready_q) begin
                    s_d   = s_q ^ c_q ^ x_ext;
                    c_d   = ((s_q & c_q) | (s_q & x_ext) | (c_q & x_ext)) << 1;
                    cnt_d = cnt_q + CNT_W'(1);
`ifdef CSA_ACC_MAX_EN
                    if (in_data > max_q) begin
                        max_d = in_data;
                    end
`endif
                    if (in_last) begin
                        state_d = RESOLVE;
                    end else if (cnt_q == CNT_W'(MAX_OPS - 1)) begin
                        state_d = RESOLVE;
                        trunc_d = 1'b1;
                    end
                end
            end
            RESOLVE: begin
                // Bits of the top chunk above ACC_W fall off the shift.
                sum_d   = (sum_q & ~(ACC_W'({DATA_W{1'b1}}) << shamt))
                        | (ACC_W'(add_sum) << shamt);
                cy_d    = add_co;
                chunk_d = chunk_q + IDX_W'(1);
                if (chunk_q == IDX_W'(NCH - 1)) begin
                    state_d = OUTPUT;
                end
            end
            OUTPUT: begin
                // out_valid is raised one cycle after entering OUTPUT so the
                // final chunk is registered before it is presented.
                if (valid_q && out_ready) begin
                    valid_d = 1'b0;
                    s_d     = '0;
                    c_d     = '0;
                    cnt_d   = '0;
                    trunc_d = 1'b0;
`ifdef CSA_ACC_MAX_EN
                    max_d   = '0;
`endif
                    state_d = ACCUM;
                end else begin
                    valid_d = 1'b1;
                end
            end
            default: begin
                state_d = ACCUM;
            end
        endcase

        in_ready_d = (state_d == ACCUM);
    end

    // State and datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ACCUM;
            s_q        <= '0;
            c_q        <= '0;
            sum_q      <= '0;
            cnt_q      <= '0;
            chunk_q    <= '0;
            cy_q       <= 1'b0;
            trunc_q    <= 1'b0;
            valid_q    <= 1'b0;
            in_ready_q <= 1'b0;
`ifdef CSA_ACC_MAX_EN
            max_q      <= '0;
`endif
        end else begin
            state_q    <= state_d;
            s_q        <= s_d;
            c_q        <= c_d;
            sum_q      <= sum_d;
            cnt_q      <= cnt_d;
            chunk_q    <= chunk_d;
            cy_q       <= cy_d;
            trunc_q    <= trunc_d;
            valid_q    <= valid_d;
            in_ready_q <= in_ready_d;
`ifdef CSA_ACC_MAX_EN
            max_q      <= max_d;
`endif
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = valid_q;
    assign out_sum   = sum_q;
    assign out_count = cnt_q;
    assign out_trunc = trunc_q;
`ifdef CSA_ACC_MAX_EN
    assign out_max   = max_q;
`endif

endmodule

// File: tb/tb_csa_accumulator.sv
// Directed self-checking bench for csa_accumulator.
// Define CSA_ACC_MAX_EN on both the RTL and this bench to exercise out_max.
module tb_csa_accumulator;
    import csa_pkg::*;

    localparam int unsigned DATA_W  = 8;
    localparam int unsigned ACC_W   = 12;
    localparam int unsigned MAX_OPS = 16;
    localparam int unsigned CNT_W   = clog2(MAX_OPS + 1);

    logic              clk;
    logic              rst;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              in_last;
    logic              out_valid;
    logic              out_ready;
    logic [ACC_W-1:0]  out_sum;
    logic [CNT_W-1:0]  out_count;
    logic              out_trunc;
`ifdef CSA_ACC_MAX_EN
    logic [DATA_W-1:0] out_max;
`endif

    int n_checks;
    int n_errors;

    csa_accumulator #(
        .DATA_W  (DATA_W),
        .ACC_W   (ACC_W),
        .MAX_OPS (MAX_OPS)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_count (out_count),
`ifdef CSA_ACC_MAX_EN
        .out_max   (out_max),
`endif
        .out_trunc (out_trunc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present one beat and hold it until accepted (bounded wait).
    task automatic send_beat(input logic [DATA_W-1:0] d, input logic last);
        int waited;
        waited   = 0;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        while (!in_ready && waited < 50) begin
            step();
            waited++;
        end
        if (!in_ready) check_eq("in_ready_timeout", 32'(in_ready), 32'd1);
        step();
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    // Wait for out_valid and return the number of cycles it took.
    task automatic wait_valid(output int lat);
        lat = 0;
        while (!out_valid && lat < 40) begin
            step();
            lat++;
        end
    endtask

    task automatic run_frame(input string tag, input int exp_sum, input int exp_cnt,
                             input logic exp_trunc);
        int lat;
        wait_valid(lat);
        check_eq({tag, "_lat"},   32'(lat),       32'd3);
        check_eq({tag, "_sum"},   32'(out_sum),   32'(exp_sum));
        check_eq({tag, "_count"}, 32'(out_count), 32'(exp_cnt));
        check_eq({tag, "_trunc"}, 32'(out_trunc), 32'(exp_trunc));
        out_ready = 1'b1;
        step();
        check_eq({tag, "_vld_clr"}, 32'(out_valid), 32'd0);
        check_eq({tag, "_rdy_up"},  32'(in_ready),  32'd1);
    endtask

    initial begin
        int lat;
        n_checks  = 0;
        n_errors  = 0;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        in_last   = 1'b0;
        out_ready = 1'b1;

        step();
        step();
        check_eq("rst_in_ready",  32'(in_ready),  32'd0);
        check_eq("rst_out_valid", 32'(out_valid), 32'd0);
        check_eq("rst_out_sum",   32'(out_sum),   32'd0);
        check_eq("rst_out_count", 32'(out_count), 32'd0);
        check_eq("rst_out_trunc", 32'(out_trunc), 32'd0);
        rst = 1'b0;
        check_eq("post_rst_in_ready_low", 32'(in_ready), 32'd0);
        step();
        check_eq("post_rst_in_ready", 32'(in_ready), 32'd1);

        // Basic three-operand frame.
        send_beat(8'd3, 1'b0);
        send_beat(8'd5, 1'b0);
        send_beat(8'd7, 1'b1);
        check_eq("f1_in_ready_low", 32'(in_ready), 32'd0);
        run_frame("f1", 15, 3, 1'b0);

        // Single-beat frame.
        send_beat(8'd200, 1'b1);
        run_frame("single", 200, 1, 1'b0);

        // Forced end after MAX_OPS beats with no last.
        for (int i = 0; i < 16; i++) send_beat(8'd255, 1'b0);
        run_frame("forced", 4080, 16, 1'b1);
        send_beat(8'd1, 1'b1);
        run_frame("after_forced", 1, 1, 1'b0);

        // Zero operands count normally.
        send_beat(8'd0, 1'b0);
        send_beat(8'd0, 1'b1);
        run_frame("zeros", 0, 2, 1'b0);

        // Backpressure: result held, extra beats ignored.
        out_ready = 1'b0;
        send_beat(8'd100, 1'b0);
        send_beat(8'd100, 1'b1);
        wait_valid(lat);
        check_eq("bp_lat", 32'(lat), 32'd3);
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            in_data  = 8'd77;
            in_last  = 1'b1;
            step();
            check_eq("bp_valid_held", 32'(out_valid), 32'd1);
            check_eq("bp_sum_held",   32'(out_sum),   32'd200);
            check_eq("bp_count_held", 32'(out_count), 32'd2);
            check_eq("bp_in_ready",   32'(in_ready),  32'd0);
        end
        in_valid  = 1'b0;
        in_last   = 1'b0;
        out_ready = 1'b1;
        step();
        check_eq("bp_release_vld",   32'(out_valid), 32'd0);
        check_eq("bp_release_rdy",   32'(in_ready),  32'd1);
        check_eq("bp_release_count", 32'(out_count), 32'd0);

        // Reset mid-frame discards the partial frame.
        send_beat(8'd10, 1'b0);
        send_beat(8'd20, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        check_eq("midrst_in_ready", 32'(in_ready),  32'd0);
        check_eq("midrst_count",    32'(out_count), 32'd0);
        step();
        rst = 1'b0;
        step();
        for (int i = 0; i < 6; i++) begin
            step();
            check_eq("midrst_no_output", 32'(out_valid), 32'd0);
        end
        send_beat(8'd1, 1'b0);
        send_beat(8'd2, 1'b1);
        run_frame("after_rst", 3, 2, 1'b0);

        // Max tracking frame (sum checked in both builds).
        send_beat(8'd9, 1'b0);
        send_beat(8'd250, 1'b0);
        send_beat(8'd17, 1'b1);
        wait_valid(lat);
`ifdef CSA_ACC_MAX_EN
        check_eq("max_out_max", 32'(out_max), 32'd250);
`endif
        check_eq("max_sum",   32'(out_sum),   32'd276);
        check_eq("max_count", 32'(out_count), 32'd3);
        step();
        check_eq("max_vld_clr", 32'(out_valid), 32'd0);
`ifdef CSA_ACC_MAX_EN
        check_eq("max_cleared", 32'(out_max), 32'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
